// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   - 3-bit state encoding of the transmit framing FSM (IDLE..STOP)
//   - line level constants for the serial output
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SYNC   = ST_SYNC,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_shifter.sv
// -----------------------------------------------------------------------------
// uart_tx_shifter
// Datapath of the transmit framer: load/shift register, data bit counter and
// running parity of the bits already driven onto the line.
// Optional feature: UART_TX_PARITY_EN adds the running parity register and the
// parity output port.
//
// Ports
//   tx_clk   in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   load     in   capture data, clear counter and parity
//   shift    in   shift right by one (bit_out advances to the next data bit)
//   cnt_inc  in   advance the data bit counter
//   data     in   word to capture on load
//   bit_out  out  current LSB of the shift register
//   last     out  counter points at the final data bit
//   parity   out  XOR of all bits shifted out since load (parity build only)
// -----------------------------------------------------------------------------
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  tx_clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  cnt_inc,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  bit_out,
    output logic                  last
`ifdef UART_TX_PARITY_EN
    ,
    output logic                  parity
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    // NOTE: the shift register is an ordinary flop bank, not a memory, so it
    // gets a defined reset value like every other piece of state.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= data;
            cnt_q   <= '0;
        end else begin
            if (shift) begin
                shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_out = shift_q[0];
    // Compare against the last index so the counter stops before it could wrap.
    assign last    = (cnt_q == CNT_W'(DATA_WIDTH - 1));

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Every data bit leaves through bit_out on a shift, so XOR-ing at shift
    // time covers the whole word by the time the last bit is on the line.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= 1'b0;
        end else if (shift) begin
            par_q <= par_q ^ shift_q[0];
        end
    end

    assign parity = par_q;
`endif

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Transmit framing engine: accepts a parallel word, enables the baud
// generator, aligns to its first tick, then serialises start, data (LSB
// first), optional parity and STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD = 1) between the data and stop bits.
//
// Ports
//   tx_clk       in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   tx_start     in   send request, sampled only in IDLE
//   tx_data      in   word to send, captured on the accepting edge
//   tx_tick      in   one-cycle bit-period strobe from the baud generator
//   baud_gen_en  out  baud generator enable, high outside IDLE
//   tx_serial    out  registered serial line, idles high
//   tx_busy      out  high from acceptance until the frame ends
//   tx_done      out  one-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  tx_clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_tick,
    output logic                  baud_gen_en,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_frame: DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    tx_state_t state_q, state_d;
    logic      serial_q, serial_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      stop_cnt_q, stop_cnt_d;

    logic      load, shift, cnt_inc;
    logic      bit_out, last;
    logic      stop_last;

`ifdef UART_TX_PARITY_EN
    logic      parity;
`endif

    uart_tx_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .tx_clk  (tx_clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .cnt_inc (cnt_inc),
        .data    (tx_data),
        .bit_out (bit_out),
        .last    (last)
`ifdef UART_TX_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    assign stop_last = (STOP_BITS == 1) || stop_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            serial_q   <= LINE_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // skipped one would infer a latch.
    always_comb begin
        state_d    = state_q;
        serial_d   = serial_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = LINE_IDLE;
                // done_q marks the cycle right after a frame; a request seen
                // then is dropped so the next acceptance is one cycle later.
                if (tx_start && !done_q) begin
                    load       = 1'b1;
                    busy_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = SYNC;
                end
            end

            SYNC: begin
                // The baud counter free-runs while disabled; waiting for its
                // first tick gives a full-width start bit.
                if (tx_tick) begin
                    serial_d = LINE_START;
                    state_d  = START;
                end
            end

            START: begin
                if (tx_tick) begin
                    serial_d = bit_out;
                    shift    = 1'b1;
                    state_d  = DATA;
                end
            end

            DATA: begin
                if (tx_tick) begin
                    if (last) begin
`ifdef UART_TX_PARITY_EN
                        serial_d = parity ^ PARITY_ODD[0];
                        state_d  = PARITY;
`else
                        serial_d = LINE_IDLE;
                        state_d  = STOP;
`endif
                    end else begin
                        serial_d = bit_out;
                        shift    = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tx_tick) begin
                    serial_d = LINE_IDLE;
                    state_d  = STOP;
                end
            end
`endif

            STOP: begin
                if (tx_tick) begin
                    if (stop_last) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                serial_d = LINE_IDLE;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign tx_serial   = serial_q;
    assign tx_busy     = busy_q;
    assign baud_gen_en = busy_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. tx_tick is free-running, one cycle in 16.
// Default build: 8N1. With UART_TX_PARITY_EN: 8 data, odd parity, 2 stop bits.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int W          = 8;
    localparam int PARITY_ODD = 1;
`ifdef UART_TX_PARITY_EN
    localparam int STOP_BITS  = 2;
    localparam int P          = 1;
`else
    localparam int STOP_BITS  = 1;
    localparam int P          = 0;
`endif
    localparam int NBITS      = 1 + W + P + STOP_BITS;
    localparam int BIT_CYC    = 16;

    logic         tx_clk = 1'b0;
    logic         rst;
    logic         tx_start;
    logic [W-1:0] tx_data;
    logic         tx_tick;
    logic         baud_gen_en;
    logic         tx_serial;
    logic         tx_busy;
    logic         tx_done;

    int n_vec = 0;
    int n_err = 0;
    int tick_phase;

    uart_tx_frame #(
        .DATA_WIDTH (W),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .tx_clk      (tx_clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_tick     (tx_tick),
        .baud_gen_en (baud_gen_en),
        .tx_serial   (tx_serial),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 tx_clk = ~tx_clk;

    // Tick source: updated 2 ns after each rising edge, high for the edge
    // that follows a phase of 0.
    initial begin
        tick_phase = 15;
        tx_tick    = 1'b0;
        forever begin
            @(posedge tx_clk);
            #2;
            tick_phase = (tick_phase == 15) ? 0 : tick_phase + 1;
            tx_tick    = (tick_phase == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame, index 0 is the start bit.
    function automatic logic [15:0] frame_bits(input logic [W-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[1 + i] = d[i];
        if (P == 1) f[1 + W] = (^d) ^ (PARITY_ODD != 0);
        return f;
    endfunction

    // Wait for the start bit; returns the number of edges waited, -1 on timeout.
    task automatic wait_fall(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge tx_clk);
            #1;
            if (tx_serial === 1'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Called with the start-bit sample (t = 0) already taken.
    task automatic check_bits(input string tag, input logic [W-1:0] d);
        logic [15:0] f;
        int b, ph;
        f = frame_bits(d);
        for (int t = 0; t <= BIT_CYC * NBITS + 1; t++) begin
            if (t > 0) begin
                @(posedge tx_clk);
                #1;
            end
            if (t < BIT_CYC * NBITS) begin
                b  = t / BIT_CYC;
                ph = t % BIT_CYC;
                if (ph == 0 || ph == BIT_CYC - 1)
                    check($sformatf("%s_bit%0d_ph%0d", tag, b, ph), tx_serial, f[b]);
                if (ph == 8) begin
                    check($sformatf("%s_busy_bit%0d", tag, b), tx_busy, 1);
                    check($sformatf("%s_baud_bit%0d", tag, b), baud_gen_en, 1);
                end
                if (ph == BIT_CYC - 1)
                    check($sformatf("%s_nodone_bit%0d", tag, b), tx_done, 0);
            end else if (t == BIT_CYC * NBITS) begin
                check({tag, "_done"}, tx_done, 1);
                check({tag, "_end_busy"}, tx_busy, 0);
                check({tag, "_end_baud"}, baud_gen_en, 0);
                check({tag, "_end_line"}, tx_serial, 1);
            end else begin
                check({tag, "_done_pulse"}, tx_done, 0);
            end
        end
    endtask

    task automatic send(input string tag, input logic [W-1:0] d);
        int c;
        @(negedge tx_clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge tx_clk);
        #1;
        check({tag, "_acc_busy"}, tx_busy, 1);
        check({tag, "_acc_baud"}, baud_gen_en, 1);
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_fall(c);
        check({tag, "_start_seen"}, (c > 0), 1);
        if (c > 0) check_bits(tag, d);
    endtask

    initial begin
        int c;
        int bad;

        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge tx_clk);
        check("rst_line", tx_serial, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_baud", baud_gen_en, 0);
        rst = 1'b1;
        repeat (5) @(negedge tx_clk);

        // Basic frame
        send("a5", 8'hA5);

        // Start while busy: a 0x3C request mid-frame must be dropped.
        fork
            send("ff", 8'hFF);
            begin
                repeat (80) @(negedge tx_clk);
                tx_data  = 8'h3C;
                tx_start = 1'b1;
                @(negedge tx_clk);
                tx_start = 1'b0;
            end
        join
        bad = 0;
        repeat (64) begin
            @(posedge tx_clk);
            #1;
            if (tx_busy !== 1'b0 || tx_serial !== 1'b1) bad++;
        end
        check("no_requeue", bad, 0);

        // Back-to-back with tx_start held high
        @(negedge tx_clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge tx_clk);
        #1;
        check("b2b_acc0", tx_busy, 1);
        @(negedge tx_clk);
        tx_data = 8'hFF;
        wait_fall(c);
        check("b2b_start0", (c > 0), 1);
        if (c > 0) check_bits("b2b0", 8'h00);
        check("b2b_ignored_on_done", tx_busy, 0);
        @(posedge tx_clk);
        #1;
        check("b2b_acc1", tx_busy, 1);
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_fall(c);
        check("b2b_start1", (c > 0), 1);
        if (c > 0) check_bits("b2b1", 8'hFF);

        // Reset during data bit 3
        @(negedge tx_clk);
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_fall(c);
        check("rmid_start", (c > 0), 1);
        repeat (4 * BIT_CYC + 8) @(posedge tx_clk);
        @(negedge tx_clk);
        check("rmid_pre_busy", tx_busy, 1);
        rst = 1'b0;
        #1;
        check("rmid_line", tx_serial, 1);
        check("rmid_busy", tx_busy, 0);
        check("rmid_baud", baud_gen_en, 0);
        check("rmid_done", tx_done, 0);
        repeat (3) @(negedge tx_clk);
        rst = 1'b1;
        repeat (3) @(negedge tx_clk);
        send("after_rst", 8'h96);

        // Parity / stop-bit frame (parity bit expected 0 when enabled)
        send("x07", 8'h07);

        // Tick alignment: request sampled 3 edges after a tick edge
        do @(negedge tx_clk); while (tick_phase != 3);
        tx_data  = 8'h81;
        tx_start = 1'b1;
        @(posedge tx_clk);
        #1;
        check("align_acc", tx_busy, 1);
        check("align_line_high", tx_serial, 1);
        @(negedge tx_clk);
        tx_start = 1'b0;
        wait_fall(c);
        check("align_fall_delay", c, 13);
        if (c > 0) check_bits("align", 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
